// File: rtl/intersection_phase_arbiter.sv
// -----------------------------------------------------------------------------
// intersection_phase_arbiter
//
// Four-approach intersection phase scheduler. One approach at a time holds the
// right-of-way. The next holder is chosen round-robin among approaches that
// have waiting cars, and a busy holder may earn a bounded number of green
// extensions. Every phase runs green -> yellow -> all-red, and the lamp codes
// for all four approaches are produced here directly.
//
// Ports:
//   clk           clock
//   rst           synchronous, active-high reset
//   cars_i        waiting cars, 8 unsigned bits per approach (approach i at
//                 cars_i[8i+7:8i])
//   light_o       lamp code per approach (approach i at light_o[2i+1:2i]):
//                 00 dark, 01 red, 10 yellow, 11 green
//   active_o      index of the approach currently holding the grant
//   phase_done_o  one-cycle pulse on the first all-red cycle after a yellow
//
// All outputs are registered. They are decoded from next-state values so that
// they change on the same edge as the state register.
// -----------------------------------------------------------------------------
module intersection_phase_arbiter #(
   parameter int GREEN_MIN    = 20,
   parameter int GREEN_EXT    = 10,
   parameter int MAX_EXT      = 2,
   parameter int YELLOW_TIME  = 3,
   parameter int ALLRED_TIME  = 2,
   parameter int HEAVY_THRESH = 45
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] cars_i,
   output logic [7:0]  light_o,
   output logic [1:0]  active_o,
   output logic        phase_done_o
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ALLRED = 2'd1,
      GREEN  = 2'd2,
      YELLOW = 2'd3
   } state_t;

   // Terminal counts: the counter runs 0..window-1.
   localparam logic [7:0] GREEN_MIN_LAST = 8'(GREEN_MIN - 1);
   localparam logic [7:0] GREEN_EXT_LAST = 8'(GREEN_EXT - 1);
   localparam logic [7:0] YELLOW_LAST    = 8'(YELLOW_TIME - 1);
   localparam logic [7:0] ALLRED_LAST    = 8'(ALLRED_TIME - 1);
   localparam logic [3:0] MAX_EXT_L      = 4'(MAX_EXT);
   localparam logic [7:0] HEAVY_L        = 8'(HEAVY_THRESH);

   localparam logic [1:0] LAMP_DARK   = 2'b00;
   localparam logic [1:0] LAMP_RED    = 2'b01;
   localparam logic [1:0] LAMP_YELLOW = 2'b10;
   localparam logic [1:0] LAMP_GREEN  = 2'b11;

   // State registers
   state_t      state;
   logic [7:0]  cnt;
   logic [3:0]  ext_cnt;
   logic [1:0]  last_grant;

   // Next-state values
   state_t      state_n;
   logic [7:0]  cnt_n;
   logic [3:0]  ext_n;
   logic [1:0]  grant_n;
   logic        done_n;
   logic [7:0]  light_n;

   // Decision helpers
   logic [7:0]  win_last;
   logic        rivals_waiting;
   logic        holder_heavy;

   // Waiting-car count of one approach.
   function automatic logic [7:0] car_count(input logic [31:0] cars,
                                            input logic [1:0]  idx);
      logic [7:0] val;
      case (idx)
         2'd0:    val = cars[7:0];
         2'd1:    val = cars[15:8];
         2'd2:    val = cars[23:16];
         2'd3:    val = cars[31:24];
         default: val = 8'd0;
      endcase
      return val;
   endfunction

   // Round-robin pick: scan last+1, last+2, last+3, last and take the first
   // approach with cars waiting. With nobody waiting the grant stays put.
   function automatic logic [1:0] rr_pick(input logic [31:0] cars,
                                          input logic [1:0]  last);
      logic [1:0] pick;
      logic [1:0] cand;
      logic       found;
      pick  = last;
      found = 1'b0;
      for (int i = 0; i < 4; i++) begin
         cand = last + 2'(i + 1);
         if (!found && (car_count(cars, cand) != 8'd0)) begin
            pick  = cand;
            found = 1'b1;
         end
      end
      return pick;
   endfunction

   // True when any approach other than the holder has cars waiting.
   function automatic logic others_waiting(input logic [31:0] cars,
                                           input logic [1:0]  holder);
      logic       any;
      logic [1:0] cand;
      any = 1'b0;
      for (int i = 1; i < 4; i++) begin
         cand = holder + 2'(i);
         any  = any | (car_count(cars, cand) != 8'd0);
      end
      return any;
   endfunction

   // Lamp codes for all four approaches given a state and the grant holder.
   // Only the holder can leave red outside IDLE, so at most one approach is
   // ever yellow or green.
   function automatic logic [7:0] lamp_decode(input state_t     st,
                                              input logic [1:0] holder);
      logic [7:0] v;
      logic       is_holder;
      v = 8'h00;
      for (int i = 0; i < 4; i++) begin
         is_holder = (2'(i) == holder);
         case (st)
            IDLE:    v[2*i +: 2] = LAMP_DARK;
            ALLRED:  v[2*i +: 2] = LAMP_RED;
            GREEN:   v[2*i +: 2] = is_holder ? LAMP_GREEN  : LAMP_RED;
            YELLOW:  v[2*i +: 2] = is_holder ? LAMP_YELLOW : LAMP_RED;
            default: v[2*i +: 2] = LAMP_DARK;
         endcase
      end
      return v;
   endfunction

   // Decision inputs for the end of a green window. A window is an extension
   // exactly when ext_cnt is non-zero, since a fresh base window clears it.
   always_comb begin
      win_last       = (ext_cnt == 4'd0) ? GREEN_MIN_LAST : GREEN_EXT_LAST;
      rivals_waiting = others_waiting(cars_i, last_grant);
      holder_heavy   = (car_count(cars_i, last_grant) >= HEAVY_L);
   end

   // Next-state, window counter and grant sequencing.
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      ext_n   = ext_cnt;
      grant_n = last_grant;
      done_n  = 1'b0;
      case (state)
         IDLE: begin
            state_n = ALLRED;
            cnt_n   = 8'd0;
         end
         ALLRED: begin
            if (cnt == ALLRED_LAST) begin
               state_n = GREEN;
               cnt_n   = 8'd0;
               ext_n   = 4'd0;
               grant_n = rr_pick(cars_i, last_grant);
            end else begin
               cnt_n = cnt + 8'd1;
            end
         end
         GREEN: begin
            if (cnt == win_last) begin
               cnt_n = 8'd0;
               if (!rivals_waiting) begin
                  // Nobody else wants the road: keep it with a fresh base window.
                  ext_n = 4'd0;
               end else if (holder_heavy && (ext_cnt < MAX_EXT_L)) begin
                  ext_n = ext_cnt + 4'd1;
               end else begin
                  state_n = YELLOW;
               end
            end else begin
               cnt_n = cnt + 8'd1;
            end
         end
         YELLOW: begin
            if (cnt == YELLOW_LAST) begin
               state_n = ALLRED;
               cnt_n   = 8'd0;
               done_n  = 1'b1;
            end else begin
               cnt_n = cnt + 8'd1;
            end
         end
         default: begin
            state_n = IDLE;
            cnt_n   = 8'd0;
            ext_n   = 4'd0;
         end
      endcase
      light_n = lamp_decode(state_n, grant_n);
   end

   // State, counters and registered outputs; reset wins on any edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         cnt          <= 8'd0;
         ext_cnt      <= 4'd0;
         last_grant   <= 2'd0;
         light_o      <= 8'h00;
         active_o     <= 2'd0;
         phase_done_o <= 1'b0;
      end else begin
         state        <= state_n;
         cnt          <= cnt_n;
         ext_cnt      <= ext_n;
         last_grant   <= grant_n;
         light_o      <= light_n;
         active_o     <= grant_n;
         phase_done_o <= done_n;
      end
   end

endmodule

// File: tb/tb_intersection_phase_arbiter.sv
// -----------------------------------------------------------------------------
// Directed testbench for intersection_phase_arbiter (default parameters).
// Outputs are sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_intersection_phase_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] cars_i;
   logic [7:0]  light_o;
   logic [1:0]  active_o;
   logic        phase_done_o;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   intersection_phase_arbiter dut (
      .clk          (clk),
      .rst          (rst),
      .cars_i       (cars_i),
      .light_o      (light_o),
      .active_o     (active_o),
      .phase_done_o (phase_done_o)
   );

   function automatic logic [31:0] cars4(input logic [7:0] c0, input logic [7:0] c1,
                                         input logic [7:0] c2, input logic [7:0] c3);
      return {c3, c2, c1, c0};
   endfunction

   // All approaches red except approach a, which shows code.
   function automatic logic [7:0] lamps(input int a, input logic [1:0] code);
      logic [7:0] v;
      v = 8'h55;
      v[2*a +: 2] = code;
      return v;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst    = 1'b1;
      cars_i = cars4(8'd10, 8'd10, 8'd10, 8'd10);
      repeat (5) step();
      checks++; if (light_o !== 8'h00) begin errors++; $display("FAIL reset_light: got %h expected 00", light_o); end
      checks++; if (active_o !== 2'd0) begin errors++; $display("FAIL reset_active: got %0d expected 0", active_o); end
      checks++; if (phase_done_o !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", phase_done_o); end
      rst = 1'b0;
      step();
      checks++; if (light_o !== 8'h55) begin errors++; $display("FAIL release_allred1: got %h expected 55", light_o); end
      step();
      checks++; if (light_o !== 8'h55) begin errors++; $display("FAIL release_allred2: got %h expected 55", light_o); end
      step();
      checks++; if (light_o !== 8'h5D) begin errors++; $display("FAIL release_green: got %h expected 5d", light_o); end
      checks++; if (active_o !== 2'd1) begin errors++; $display("FAIL release_active: got %0d expected 1", active_o); end
   endtask

   // Entered on the first green cycle of approach 1.
   task automatic test_round_robin();
      int seq [5] = '{1, 2, 3, 0, 1};
      int ng, ny, na, extra;
      logic pd_first;
      logic [1:0] act;
      for (int k = 0; k < 4; k++) begin
         ng = 0; ny = 0; na = 0; extra = 0;
         while (light_o === lamps(seq[k], 2'b11) && ng < 200) begin
            if (phase_done_o) extra++;
            ng++; step();
         end
         while (light_o === lamps(seq[k], 2'b10) && ny < 20) begin
            if (phase_done_o) extra++;
            ny++; step();
         end
         pd_first = phase_done_o;
         act      = active_o;
         while (light_o === 8'h55 && na < 20) begin
            if (phase_done_o && na > 0) extra++;
            na++; step();
         end
         checks++; if (ng != 20) begin errors++; $display("FAIL rr_green_len[%0d]: got %0d expected 20", k, ng); end
         checks++; if (ny != 3) begin errors++; $display("FAIL rr_yellow_len[%0d]: got %0d expected 3", k, ny); end
         checks++; if (na != 2) begin errors++; $display("FAIL rr_allred_len[%0d]: got %0d expected 2", k, na); end
         checks++; if (pd_first !== 1'b1) begin errors++; $display("FAIL rr_done_pulse[%0d]: got %b expected 1", k, pd_first); end
         checks++; if (extra != 0) begin errors++; $display("FAIL rr_done_extra[%0d]: got %0d stray pulses expected 0", k, extra); end
         checks++; if (ng + ny + na != 25) begin errors++; $display("FAIL rr_phase_len[%0d]: got %0d expected 25", k, ng + ny + na); end
         checks++; if (act !== 2'(seq[k])) begin errors++; $display("FAIL rr_active_hold[%0d]: got %0d expected %0d", k, act, seq[k]); end
         checks++; if (light_o !== lamps(seq[k+1], 2'b11)) begin errors++; $display("FAIL rr_next_green[%0d]: got %h expected %h", k, light_o, lamps(seq[k+1], 2'b11)); end
         checks++; if (active_o !== 2'(seq[k+1])) begin errors++; $display("FAIL rr_next_active[%0d]: got %0d expected %0d", k, active_o, seq[k+1]); end
      end
   endtask

   // Entered on the first green cycle of approach 1.
   task automatic test_heavy_extension();
      int ng, ny, na;
      cars_i = cars4(8'd10, 8'd50, 8'd10, 8'd10);
      ng = 0; ny = 0; na = 0;
      while (light_o === 8'h5D && ng < 200) begin ng++; step(); end
      while (light_o === 8'h59 && ny < 20) begin ny++; step(); end
      while (light_o === 8'h55 && na < 20) begin na++; step(); end
      checks++; if (ng != 40) begin errors++; $display("FAIL heavy_green_len: got %0d expected 40", ng); end
      checks++; if (ny != 3) begin errors++; $display("FAIL heavy_yellow_len: got %0d expected 3", ny); end
      checks++; if (na != 2) begin errors++; $display("FAIL heavy_allred_len: got %0d expected 2", na); end
      checks++; if (light_o !== 8'h75) begin errors++; $display("FAIL heavy_next_green: got %h expected 75", light_o); end
      cars_i = cars4(8'd10, 8'd10, 8'd10, 8'd10);
   endtask

   // Entered during approach 2 green; last grant before reset is 2.
   task automatic test_reset_mid_yellow();
      int n;
      n = 0;
      while (light_o !== 8'h65 && n < 100) begin n++; step(); end
      checks++; if (n >= 100) begin errors++; $display("FAIL midy_reach_yellow: got %h expected 65 within 100 cycles", light_o); end
      step();
      checks++; if (light_o !== 8'h65) begin errors++; $display("FAIL midy_still_yellow: got %h expected 65", light_o); end
      rst = 1'b1;
      step();
      rst = 1'b0;
      checks++; if (light_o !== 8'h00) begin errors++; $display("FAIL midy_reset_light: got %h expected 00", light_o); end
      checks++; if (active_o !== 2'd0) begin errors++; $display("FAIL midy_reset_active: got %0d expected 0", active_o); end
      checks++; if (phase_done_o !== 1'b0) begin errors++; $display("FAIL midy_reset_done: got %b expected 0", phase_done_o); end
      step();
      checks++; if (light_o !== 8'h55) begin errors++; $display("FAIL midy_allred1: got %h expected 55", light_o); end
      step();
      checks++; if (light_o !== 8'h55) begin errors++; $display("FAIL midy_allred2: got %h expected 55", light_o); end
      step();
      checks++; if (light_o !== 8'h5D) begin errors++; $display("FAIL midy_regrant_light: got %h expected 5d", light_o); end
      checks++; if (active_o !== 2'd1) begin errors++; $display("FAIL midy_regrant_active: got %0d expected 1", active_o); end
   endtask

   task automatic test_solo_hold();
      int bad, ng, ny, na;
      logic pd_first;
      rst    = 1'b1;
      cars_i = cars4(8'd0, 8'd0, 8'd5, 8'd0);
      step();
      rst = 1'b0;
      repeat (3) step();
      checks++; if (light_o !== 8'h75) begin errors++; $display("FAIL solo_grant_light: got %h expected 75", light_o); end
      checks++; if (active_o !== 2'd2) begin errors++; $display("FAIL solo_grant_active: got %0d expected 2", active_o); end
      bad = 0;
      repeat (70) begin
         step();
         if (light_o !== 8'h75 || phase_done_o !== 1'b0) bad++;
      end
      checks++; if (bad != 0) begin errors++; $display("FAIL solo_hold: got %0d deviating cycles expected 0", bad); end
      // Ten cycles into the current base window.
      cars_i = cars4(8'd1, 8'd0, 8'd5, 8'd0);
      ng = 0; ny = 0; na = 0;
      while (light_o === 8'h75 && ng < 200) begin ng++; step(); end
      while (light_o === 8'h65 && ny < 20) begin ny++; step(); end
      pd_first = phase_done_o;
      while (light_o === 8'h55 && na < 20) begin na++; step(); end
      checks++; if (ng != 10) begin errors++; $display("FAIL solo_green_remaining: got %0d expected 10", ng); end
      checks++; if (ny != 3) begin errors++; $display("FAIL solo_yellow_len: got %0d expected 3", ny); end
      checks++; if (pd_first !== 1'b1) begin errors++; $display("FAIL solo_done_pulse: got %b expected 1", pd_first); end
      checks++; if (light_o !== 8'h57) begin errors++; $display("FAIL solo_next_light: got %h expected 57", light_o); end
      checks++; if (active_o !== 2'd0) begin errors++; $display("FAIL solo_next_active: got %0d expected 0", active_o); end
   endtask

   task automatic test_empty_intersection();
      int bad;
      rst    = 1'b1;
      cars_i = cars4(8'd0, 8'd0, 8'd0, 8'd0);
      step();
      rst = 1'b0;
      repeat (3) step();
      checks++; if (light_o !== 8'h57) begin errors++; $display("FAIL empty_grant_light: got %h expected 57", light_o); end
      checks++; if (active_o !== 2'd0) begin errors++; $display("FAIL empty_grant_active: got %0d expected 0", active_o); end
      bad = 0;
      repeat (50) begin
         step();
         if (light_o !== 8'h57 || phase_done_o !== 1'b0) bad++;
      end
      checks++; if (bad != 0) begin errors++; $display("FAIL empty_hold: got %0d deviating cycles expected 0", bad); end
   endtask

   initial begin
      rst    = 1'b1;
      cars_i = 32'd0;
      test_reset();
      test_round_robin();
      test_heavy_extension();
      test_reset_mid_yellow();
      test_solo_hold();
      test_empty_intersection();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
